sqrt_newton_iter: RTL

Sequential integer Newton–Raphson refinement stage of the square-root finder. It sits directly downstream of the combinational initial-guess stage. It consumes the 20-bit radicand and the 17-bit power-of-two seed, and iterates x ← ⌊(x + ⌊N/x⌋)/2⌋ using a shared multi-cycle divider. It returns ⌊√N⌋ as a 10-bit root with a one-cycle completion pulse.

---
 rtl/sqrt_newton_iter_pkg.sv | 18 +
 rtl/sqrt_newton_iter_if.sv | 22 ++
 rtl/sqrt_newton_iter_seq_divider.sv | 78 +++++++
 rtl/sqrt_newton_iter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/sqrt_newton_iter_pkg.sv
// Shared widths, state encoding and constants for the square-root refinement stage.
package sqrt_pkg;
    localparam int N_W    = 20;
    localparam int SEED_W = 17;
    localparam int ROOT_W = 10;

    // No 20-bit radicand has a root at or above this value, so it is a safe upper seed.
    localparam logic [N_W-1:0] SEED_FALLBACK = 20'd1024;
    localparam logic [N_W-1:0] ROOT_MAX      = 20'd1023;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_DIV,
        S_UPDATE,
        S_DONE
    } state_t;
endpackage

// File: rtl/sqrt_newton_iter_if.sv
// Request/response bundle between the requester and the Newton refinement stage.
interface sqrt_newton_iter_if;
    import sqrt_pkg::*;

    logic              start;
    logic [N_W-1:0]    val_in;
    logic [SEED_W-1:0] init_value;
    logic              busy;
    logic              done;
    logic [ROOT_W-1:0] root;
    logic              ovf;

    modport master (
        output start, val_in, init_value,
        input  busy, done, root, ovf
    );

    modport slave (
        input  start, val_in, init_value,
        output busy, done, root, ovf
    );
endinterface

// File: rtl/sqrt_newton_iter_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle; the first bit is resolved on the go edge.
module seq_divider
    import sqrt_pkg::*;
#(
    parameter int DATA_W = N_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              go,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              q_valid,
    output logic [DATA_W-1:0] quotient
);
    localparam int C_W = $clog2(DATA_W + 1);

    typedef struct packed {
        logic [DATA_W-1:0] rem;
        logic [DATA_W-1:0] quo;
    } step_t;

    logic [DATA_W-1:0] rem_r;
    logic [DATA_W-1:0] quo_r;
    logic [DATA_W-1:0] dvs_r;
    logic [C_W-1:0]    cnt_r;
    logic              q_valid_r;
    step_t             step_nxt;

    function automatic step_t div_step(input logic [DATA_W-1:0] rem,
                                       input logic [DATA_W-1:0] quo,
                                       input logic [DATA_W-1:0] dvs);
        logic [DATA_W:0] trial;
        logic [DATA_W:0] diff;
        step_t           r;
        trial = {rem, quo[DATA_W-1]};
        diff  = trial - {1'b0, dvs};
        if (trial >= {1'b0, dvs}) begin
            r.rem = diff[DATA_W-1:0];
            r.quo = {quo[DATA_W-2:0], 1'b1};
        end else begin
            r.rem = trial[DATA_W-1:0];
            r.quo = {quo[DATA_W-2:0], 1'b0};
        end
        return r;
    endfunction

    always_comb begin
        step_nxt = go ? div_step('0, dividend, divisor) : div_step(rem_r, quo_r, dvs_r);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_r     <= '0;
            quo_r     <= '0;
            dvs_r     <= '0;
            cnt_r     <= '0;
            q_valid_r <= 1'b0;
        end else begin
            q_valid_r <= 1'b0;
            if (go) begin
                rem_r <= step_nxt.rem;
                quo_r <= step_nxt.quo;
                dvs_r <= divisor;
                cnt_r <= C_W'(DATA_W - 1);
            end else if (cnt_r != '0) begin
                rem_r     <= step_nxt.rem;
                quo_r     <= step_nxt.quo;
                cnt_r     <= cnt_r - C_W'(1);
                q_valid_r <= (cnt_r == C_W'(1));
            end
        end
    end

    assign busy     = (cnt_r != '0);
    assign q_valid  = q_valid_r;
    assign quotient = quo_r;
endmodule

// File: rtl/sqrt_newton_iter.sv
// Newton-Raphson integer square-root refinement: x <- (x + N/x) / 2 until it stops decreasing.
module sqrt_newton_iter
    import sqrt_pkg::*;
#(
    parameter int MAX_ITER = 24
) (
    input logic               clk,
    input logic               rst,
    sqrt_newton_iter_if.slave bus
);
    localparam int K_W = $clog2(MAX_ITER + 1);

    state_t            state, state_nxt;
    logic [N_W-1:0]    n_r, n_nxt;
    logic [N_W-1:0]    x_r, x_nxt;
    logic [K_W-1:0]    k_r, k_nxt;
    logic              ovf_it_r, ovf_it_nxt;
    logic              done_r;
    logic [ROOT_W-1:0] root_r;
    logic              ovf_r;

    logic              launch;
    logic              div_go;
    logic [N_W-1:0]    div_divisor;
    logic              div_busy;
    logic              div_valid;
    logic [N_W-1:0]    div_q;
    logic [N_W:0]      sum;
    logic [N_W-1:0]    y;

    function automatic logic [ROOT_W-1:0] sat_root(input logic [N_W-1:0] v);
        return (v > ROOT_MAX) ? ROOT_MAX[ROOT_W-1:0] : v[ROOT_W-1:0];
    endfunction

    seq_divider #(.DATA_W(N_W)) u_div (
        .clk      (clk),
        .rst      (rst),
        .go       (div_go),
        .dividend (n_r),
        .divisor  (div_divisor),
        .busy     (div_busy),
        .q_valid  (div_valid),
        .quotient (div_q)
    );

    assign div_go = launch && !div_busy;
    assign sum    = {1'b0, x_r} + {1'b0, div_q};
    assign y      = sum[N_W:1];

    always_comb begin
        state_nxt   = state;
        n_nxt       = n_r;
        x_nxt       = x_r;
        k_nxt       = k_r;
        ovf_it_nxt  = ovf_it_r;
        launch      = 1'b0;
        div_divisor = x_r;
        case (state)
            S_IDLE: begin
                // The done cycle still belongs to the finished run, so no accept there.
                if (bus.start && !done_r) begin
                    n_nxt      = bus.val_in;
                    x_nxt      = {{(N_W-SEED_W){1'b0}}, bus.init_value};
                    k_nxt      = '0;
                    ovf_it_nxt = 1'b0;
                    state_nxt  = S_LOAD;
                end
            end
            S_LOAD: begin
                if (n_r == '0) begin
                    x_nxt     = '0;
                    state_nxt = S_DONE;
                end else begin
                    if (x_r == '0) begin
                        x_nxt       = SEED_FALLBACK;
                        div_divisor = SEED_FALLBACK;
                    end
                    launch    = 1'b1;
                    state_nxt = S_DIV;
                end
            end
            S_DIV: begin
                if (div_valid) state_nxt = S_UPDATE;
            end
            S_UPDATE: begin
                k_nxt = k_r + K_W'(1);
                // First step is unconditional so a low seed ends up at or above the root.
                if (k_r == '0) begin
                    x_nxt       = y;
                    div_divisor = y;
                    launch      = 1'b1;
                    state_nxt   = S_DIV;
                end else if (y >= x_r) begin
                    state_nxt = S_DONE;
                end else begin
                    x_nxt = y;
                    if (k_nxt == K_W'(MAX_ITER)) begin
                        ovf_it_nxt = 1'b1;
                        state_nxt  = S_DONE;
                    end else begin
                        div_divisor = y;
                        launch      = 1'b1;
                        state_nxt   = S_DIV;
                    end
                end
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            n_r      <= '0;
            x_r      <= '0;
            k_r      <= '0;
            ovf_it_r <= 1'b0;
            done_r   <= 1'b0;
            root_r   <= '0;
            ovf_r    <= 1'b0;
        end else begin
            state    <= state_nxt;
            n_r      <= n_nxt;
            x_r      <= x_nxt;
            k_r      <= k_nxt;
            ovf_it_r <= ovf_it_nxt;
            done_r   <= (state == S_DONE);
            if (state == S_DONE) begin
                root_r <= sat_root(x_r);
                ovf_r  <= ovf_it_r || (x_r > ROOT_MAX);
            end
        end
    end

    assign bus.busy = (state != S_IDLE) || done_r;
    assign bus.done = done_r;
    assign bus.root = root_r;
    assign bus.ovf  = ovf_r;
endmodule
